// File: rtl/bp_fe_mock_pkg.sv
// Shared types and helpers for the mock front end that feeds a BE-only bench.
package bp_fe_mock_pkg;

  typedef enum logic [1:0] {
    e_run   = 2'd0,
    e_fence = 2'd1,
    e_exc   = 2'd2,
    e_stall = 2'd3
  } bp_fe_mock_state_e;

  typedef enum logic [2:0] {
    e_op_pc_redirect  = 3'd0,
    e_op_state_reset  = 3'd1,
    e_op_icache_fence = 3'd2
  } bp_fe_mock_cmd_e;

  localparam logic e_mock_msg_fetch = 1'b0;
  localparam logic e_mock_msg_exc   = 1'b1;

  // Synthetic instruction word: low PC bits shifted up, tagged with 2'b11.
  function automatic logic [31:0] mock_instr(input logic [29:0] pc_low);
    return {pc_low, 2'b11};
  endfunction

endpackage

// File: rtl/bp_fe_mock_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module bp_fe_mock_sat_counter
  import bp_fe_mock_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [width_p-1:0] count
);

  logic [width_p-1:0] count_r;

  // Count register: clear, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {width_p{1'b1}})) begin
      count_r <= count_r + width_p'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/bp_fe_mock_fe_stream.sv
// Mock FE: streams sequential fetch packets and obeys BE commands.
// Define BP_FE_MOCK_FE_PERF_EN to build the fetch/command counters.
module bp_fe_mock_fe_stream
  import bp_fe_mock_pkg::*;
#(
  parameter int                       vaddr_width_p   = 39,
  parameter logic [vaddr_width_p-1:0] boot_pc_p       = 39'h0080000000,
  parameter int                       fence_latency_p = 8,
  parameter int                       cnt_width_p     = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  output logic                     fe_queue_v_o,
  input  logic                     fe_queue_ready_i,
  output logic                     fe_queue_msg_type_o,
  output logic [vaddr_width_p-1:0] fe_queue_pc_o,
  output logic [31:0]              fe_queue_instr_o,
  input  logic                     fe_cmd_v_i,
  input  logic [2:0]               fe_cmd_opcode_i,
  input  logic [vaddr_width_p-1:0] fe_cmd_pc_i,
  output logic                     fe_cmd_yumi_o,
  output logic [cnt_width_p-1:0]   fetch_count_o,
  output logic [cnt_width_p-1:0]   cmd_count_o
);

  localparam int fence_cnt_width_lp = $clog2(fence_latency_p + 1);
  localparam logic [fence_cnt_width_lp-1:0] fence_load_lp = fence_cnt_width_lp'(fence_latency_p);
  localparam bp_fe_mock_state_e reset_state_lp = (boot_pc_p[1:0] != 2'b00) ? e_exc : e_run;

  bp_fe_mock_state_e             state_r, state_n_s;
  logic [vaddr_width_p-1:0]      pc_r, pc_n_s;
  logic [fence_cnt_width_lp-1:0] fence_cnt_r, fence_cnt_n_s;
  logic                          pkt_v_s, transfer_s, yumi_s;

  // Outputs are forced quiet while reset is held, even though state_r resets to e_run.
  assign pkt_v_s    = (state_r == e_run) || (state_r == e_exc);
  assign transfer_s = fe_queue_v_o & fe_queue_ready_i;
  assign yumi_s     = reset_n_i & fe_cmd_v_i & (state_r != e_fence) & (~pkt_v_s | fe_queue_ready_i);

  assign fe_queue_v_o        = reset_n_i & pkt_v_s;
  assign fe_queue_msg_type_o = (state_r == e_exc) ? e_mock_msg_exc : e_mock_msg_fetch;
  assign fe_queue_pc_o       = pc_r;
  assign fe_queue_instr_o    = (state_r == e_exc) ? 32'h0000_0000 : mock_instr(pc_r[29:0]);
  assign fe_cmd_yumi_o       = yumi_s;

  // Next-state logic: packet progress first, then an accepted command overrides it.
  always_comb begin
    state_n_s     = state_r;
    pc_n_s        = pc_r;
    fence_cnt_n_s = fence_cnt_r;
    case (state_r)
      e_run: begin
        if (transfer_s) pc_n_s = pc_r + vaddr_width_p'(4);
        else            pc_n_s = pc_r;
      end
      e_exc: begin
        if (transfer_s) state_n_s = e_stall;
        else            state_n_s = state_r;
      end
      e_fence: begin
        fence_cnt_n_s = fence_cnt_r - fence_cnt_width_lp'(1);
        if (fence_cnt_r == fence_cnt_width_lp'(1))
          state_n_s = (pc_r[1:0] != 2'b00) ? e_exc : e_run;
        else
          state_n_s = state_r;
      end
      e_stall: state_n_s = state_r;
      default: state_n_s = reset_state_lp;
    endcase

    if (yumi_s) begin
      case (fe_cmd_opcode_i)
        e_op_pc_redirect, e_op_state_reset: begin
          pc_n_s    = fe_cmd_pc_i;
          state_n_s = (fe_cmd_pc_i[1:0] != 2'b00) ? e_exc : e_run;
        end
        e_op_icache_fence: begin
          state_n_s     = e_fence;
          fence_cnt_n_s = fence_load_lp;
        end
        default: state_n_s = state_n_s;
      endcase
    end else begin
      state_n_s = state_n_s;
    end
  end

  // State, PC and fence-counter registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= reset_state_lp;
      pc_r        <= boot_pc_p;
      fence_cnt_r <= '0;
    end else begin
      state_r     <= state_n_s;
      pc_r        <= pc_n_s;
      fence_cnt_r <= fence_cnt_n_s;
    end
  end

`ifdef BP_FE_MOCK_FE_PERF_EN
  logic fetch_inc_s, fetch_clr_s;

  assign fetch_inc_s = transfer_s & (fe_queue_msg_type_o == e_mock_msg_fetch);
  assign fetch_clr_s = yumi_s & (fe_cmd_opcode_i == e_op_state_reset);

  bp_fe_mock_sat_counter #(.width_p(cnt_width_p)) fetch_cnt (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .clr   (fetch_clr_s),
    .inc   (fetch_inc_s),
    .count (fetch_count_o)
  );

  bp_fe_mock_sat_counter #(.width_p(cnt_width_p)) cmd_cnt (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .clr   (1'b0),
    .inc   (yumi_s),
    .count (cmd_count_o)
  );
`else
  assign fetch_count_o = '0;
  assign cmd_count_o   = '0;
`endif

endmodule

// File: tb/tb_bp_fe_mock_fe_stream.sv
// Directed, table-driven bench for the mock FE stream.
module tb_bp_fe_mock_fe_stream;

  logic        clk;
  logic        rst_n;
  logic        fe_queue_v;
  logic        fe_queue_ready;
  logic        fe_queue_msg_type;
  logic [38:0] fe_queue_pc;
  logic [31:0] fe_queue_instr;
  logic        fe_cmd_v;
  logic [2:0]  fe_cmd_opcode;
  logic [38:0] fe_cmd_pc;
  logic        fe_cmd_yumi;
  logic [31:0] fetch_count;
  logic [31:0] cmd_count;

  int n_cmp = 0;
  int n_err = 0;

  bp_fe_mock_fe_stream #(
    .vaddr_width_p  (39),
    .boot_pc_p      (39'h0080000000),
    .fence_latency_p(8),
    .cnt_width_p    (32)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (rst_n),
    .fe_queue_v_o       (fe_queue_v),
    .fe_queue_ready_i   (fe_queue_ready),
    .fe_queue_msg_type_o(fe_queue_msg_type),
    .fe_queue_pc_o      (fe_queue_pc),
    .fe_queue_instr_o   (fe_queue_instr),
    .fe_cmd_v_i         (fe_cmd_v),
    .fe_cmd_opcode_i    (fe_cmd_opcode),
    .fe_cmd_pc_i        (fe_cmd_pc),
    .fe_cmd_yumi_o      (fe_cmd_yumi),
    .fetch_count_o      (fetch_count),
    .cmd_count_o        (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        cmd_v;
    logic [2:0]  op;
    logic [38:0] cmd_pc;
    logic        exp_v;
    logic        exp_type;
    logic [38:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_yumi;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic cv, input logic [2:0] op, input logic [38:0] p);
    fe_queue_ready = r;
    fe_cmd_v       = cv;
    fe_cmd_opcode  = op;
    fe_cmd_pc      = p;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input string name, input logic t, input logic [38:0] p, input logic [31:0] ins);
    chk({name, ".v"}, {63'd0, fe_queue_v}, 64'd1);
    chk({name, ".type"}, {63'd0, fe_queue_msg_type}, {63'd0, t});
    chk({name, ".pc"}, {25'd0, fe_queue_pc}, {25'd0, p});
    chk({name, ".instr"}, {32'd0, fe_queue_instr}, {32'd0, ins});
  endtask

  task automatic chk_counts(input string name, input logic [31:0] f, input logic [31:0] c);
`ifdef BP_FE_MOCK_FE_PERF_EN
    chk({name, ".fetch_cnt"}, {32'd0, fetch_count}, {32'd0, f});
    chk({name, ".cmd_cnt"}, {32'd0, cmd_count}, {32'd0, c});
`else
    chk({name, ".fetch_cnt"}, {32'd0, fetch_count}, 64'd0);
    chk({name, ".cmd_cnt"}, {32'd0, cmd_count}, 64'd0);
`endif
  endtask

  initial begin
    //          ready cmd_v op    cmd_pc              v     type  pc                  instr          yumi
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 39'h0,             1'b1, 1'b0, 39'h0080000000, 32'h00000003, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 39'h0,             1'b1, 1'b0, 39'h0080000004, 32'h00000013, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd0, 39'h0,             1'b1, 1'b0, 39'h0080000008, 32'h00000023, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'd0, 39'h0080000400,    1'b1, 1'b0, 39'h008000000C, 32'h00000033, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'd0, 39'h0080000400,    1'b1, 1'b0, 39'h008000000C, 32'h00000033, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'd0, 39'h0080000400,    1'b1, 1'b0, 39'h008000000C, 32'h00000033, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'd0, 39'h0080000400,    1'b1, 1'b0, 39'h008000000C, 32'h00000033, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'd0, 39'h0080000400,    1'b1, 1'b0, 39'h008000000C, 32'h00000033, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'd0, 39'h0080000400,    1'b1, 1'b0, 39'h008000000C, 32'h00000033, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 39'h0,             1'b1, 1'b0, 39'h0080000400, 32'h00001003, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 3'd0, 39'h0080000102,    1'b1, 1'b0, 39'h0080000404, 32'h00001013, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 39'h0,             1'b1, 1'b1, 39'h0080000102, 32'h00000000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'd0, 39'h0,             1'b1, 1'b1, 39'h0080000102, 32'h00000000, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'd0, 39'h0,             1'b0, 1'b0, 39'h0,          32'h00000000, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 3'd3, 39'h0,             1'b0, 1'b0, 39'h0,          32'h00000000, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 3'd0, 39'h0080000200,    1'b0, 1'b0, 39'h0,          32'h00000000, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 3'd0, 39'h0,             1'b1, 1'b0, 39'h0080000200, 32'h00000803, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'd0, 39'h0,             1'b1, 1'b0, 39'h0080000204, 32'h00000813, 1'b0};

    rst_n = 1'b0;
    drive(1'b1, 1'b1, 3'd3, 39'h0);
    next_cycle();
    @(negedge clk);
    chk("reset.v", {63'd0, fe_queue_v}, 64'd0);
    chk("reset.yumi", {63'd0, fe_cmd_yumi}, 64'd0);
    chk_counts("reset", 32'd0, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ready, vecs[i].cmd_v, vecs[i].op, vecs[i].cmd_pc);
      @(negedge clk);
      chk($sformatf("vec%0d.v", i), {63'd0, fe_queue_v}, {63'd0, vecs[i].exp_v});
      chk($sformatf("vec%0d.yumi", i), {63'd0, fe_cmd_yumi}, {63'd0, vecs[i].exp_yumi});
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d.type", i), {63'd0, fe_queue_msg_type}, {63'd0, vecs[i].exp_type});
        chk($sformatf("vec%0d.pc", i), {25'd0, fe_queue_pc}, {25'd0, vecs[i].exp_pc});
        chk($sformatf("vec%0d.instr", i), {32'd0, fe_queue_instr}, {32'd0, vecs[i].exp_instr});
      end
      next_cycle();
    end

    // Fence taken alongside a transfer; a redirect offered during the fence is refused.
    drive(1'b1, 1'b1, 3'd2, 39'h0);
    @(negedge clk);
    chk_pkt("fence.t", 1'b0, 39'h0080000208, 32'h00000823);
    chk("fence.t.yumi", {63'd0, fe_cmd_yumi}, 64'd1);
    next_cycle();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b1, 3'd0, 39'h0000123400);
      @(negedge clk);
      chk($sformatf("fence.t+%0d.v", k), {63'd0, fe_queue_v}, 64'd0);
      chk($sformatf("fence.t+%0d.yumi", k), {63'd0, fe_cmd_yumi}, 64'd0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 3'd0, 39'h0);
    @(negedge clk);
    chk_pkt("fence.resume", 1'b0, 39'h008000020C, 32'h00000833);
    next_cycle();

    // PC wrap at the top of the address space.
    drive(1'b1, 1'b1, 3'd0, 39'h7FFFFFFFFC);
    @(negedge clk);
    chk("wrap.redir.yumi", {63'd0, fe_cmd_yumi}, 64'd1);
    next_cycle();
    drive(1'b1, 1'b0, 3'd0, 39'h0);
    @(negedge clk);
    chk_pkt("wrap.top", 1'b0, 39'h7FFFFFFFFC, 32'hFFFFFFF3);
    next_cycle();
    @(negedge clk);
    chk_pkt("wrap.zero", 1'b0, 39'h0, 32'h00000003);
    next_cycle();

    // Asynchronous reset while an exception packet is stalled.
    drive(1'b1, 1'b1, 3'd0, 39'h0080000006);
    @(negedge clk);
    chk("rst.redir.yumi", {63'd0, fe_cmd_yumi}, 64'd1);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 39'h0);
    @(negedge clk);
    chk_pkt("rst.exc", 1'b1, 39'h0080000006, 32'h00000000);
    #2;
    drive(1'b1, 1'b1, 3'd3, 39'h0);
    rst_n = 1'b0;
    #1;
    chk("rst.async.v", {63'd0, fe_queue_v}, 64'd0);
    chk("rst.async.yumi", {63'd0, fe_cmd_yumi}, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 39'h0);
    @(negedge clk);
    chk_pkt("rst.boot", 1'b0, 39'h0080000000, 32'h00000003);
    chk_counts("rst.boot", 32'd0, 32'd0);
    next_cycle();
    @(negedge clk);
    chk_pkt("cnt.f2", 1'b0, 39'h0080000004, 32'h00000013);
    next_cycle();
    @(negedge clk);
    chk_pkt("cnt.f3", 1'b0, 39'h0080000008, 32'h00000023);
    next_cycle();
    drive(1'b1, 1'b1, 3'd1, 39'h0080000000);
    @(negedge clk);
    chk_counts("cnt.three", 32'd3, 32'd0);
    chk("cnt.sreset.yumi", {63'd0, fe_cmd_yumi}, 64'd1);
    next_cycle();
    drive(1'b1, 1'b0, 3'd0, 39'h0);
    @(negedge clk);
    chk_pkt("cnt.after", 1'b0, 39'h0080000000, 32'h00000003);
    chk_counts("cnt.after", 32'd0, 32'd1);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
